// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM states and byte helpers
// Contents: round counts per key size, FSM state enum, GF(2^8) xtime,
// and the (row, column) -> bit-position helper for the 128-bit state.
package aes_pkg;

   localparam int NR_128 = 10;
   localparam int NR_192 = 12;
   localparam int NR_256 = 14;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } aes_state_e;

   // Multiply by x in GF(2^8) modulo 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // MSB bit index of state byte (row r, column c); byte 0 sits at [127:120].
   function automatic int byte_msb(input int r, input int c);
      return 127 - 8 * (4 * c + r);
   endfunction

endpackage

// File: rtl/aes_enc_round.sv
// rtl/aes_enc_round.sv - one combinational forward AES round
// Ports: state (current state), rk (round key), last_round (skip MixColumns),
// next_state (state after SubBytes, ShiftRows, [MixColumns], AddRoundKey).
module aes_enc_round (
   input  logic [127:0] state,
   input  logic [127:0] rk,
   input  logic         last_round,
   output logic [127:0] next_state
);

   logic [127:0] sb_out;
   logic [127:0] sr_out;
   logic [127:0] mc_out;

   sub_byte    u_sub (.din(state),  .dout(sb_out));
   shift_row   u_sr  (.din(sb_out), .dout(sr_out));
   mix_columns u_mc  (.din(sr_out), .dout(mc_out));

   assign next_state = (last_round ? sr_out : mc_out) ^ rk;

endmodule

// File: rtl/mix_columns.sv
// rtl/mix_columns.sv - forward MixColumns, matrix rows [2 3 1 1] rotated
// Ports: din (128-bit state in), dout (128-bit mixed state).
module mix_columns
   import aes_pkg::*;
(
   input  logic [127:0] din,
   output logic [127:0] dout
);

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = din[byte_msb(0, c) -: 8];
      assign a1 = din[byte_msb(1, c) -: 8];
      assign a2 = din[byte_msb(2, c) -: 8];
      assign a3 = din[byte_msb(3, c) -: 8];

      // 3*b is expressed as xtime(b) ^ b.
      assign dout[byte_msb(0, c) -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign dout[byte_msb(1, c) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign dout[byte_msb(2, c) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign dout[byte_msb(3, c) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
   end

endmodule

// File: rtl/shift_row.sv
// rtl/shift_row.sv - forward ShiftRows: out(r,c) = in(r,(c+r) mod 4)
// Ports: din (128-bit state in), dout (128-bit shifted state).
module shift_row
   import aes_pkg::*;
(
   input  logic [127:0] din,
   output logic [127:0] dout
);

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         localparam int DST = byte_msb(r, c);
         localparam int SRC = byte_msb(r, (c + r) % 4);
         assign dout[DST -: 8] = din[SRC -: 8];
      end
   end

endmodule

// File: rtl/sub_byte.sv
// rtl/sub_byte.sv - forward SubBytes over all 16 state bytes
// Ports: din (128-bit state in), dout (128-bit state with S-box applied).
module sub_byte (
   input  logic [127:0] din,
   output logic [127:0] dout
);

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   for (genvar i = 0; i < 16; i++) begin : g_byte
      assign dout[8*i +: 8] = SBOX[din[8*i +: 8]];
   end

endmodule

// File: rtl/aes_encrypt_iter.sv
// rtl/aes_encrypt_iter.sv - iterative AES encryption core, one round per cycle
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_data plaintext
// handshake; rk_idx/rk_data round-key store read port (combinational);
// out_valid/out_ready/out_data ciphertext handshake; busy high in RUN and DONE.
module aes_encrypt_iter
   import aes_pkg::*;
#(
   parameter int NR  = 10,
   parameter int RKW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [127:0]   in_data,
   output logic [RKW-1:0] rk_idx,
   input  logic [127:0]   rk_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [127:0]   out_data,
   output logic           busy
);

   if (!(NR == NR_128 || NR == NR_192 || NR == NR_256)) begin : g_bad_nr
      $error("aes_encrypt_iter: NR must be 10, 12 or 14");
   end
   if ((1 << RKW) <= NR) begin : g_bad_rkw
      $error("aes_encrypt_iter: RKW too narrow to index round NR");
   end

   aes_state_e     state_q, state_d;
   logic [RKW-1:0] rnd_q, rnd_d;
   logic [127:0]   data_q, data_d;
   logic [127:0]   round_out;
   logic           last_round;

   assign last_round = (rnd_q == RKW'(NR));

   aes_enc_round u_round (
      .state      (data_q),
      .rk         (rk_data),
      .last_round (last_round),
      .next_state (round_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rnd_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rnd_d     = rnd_q;
      data_d    = data_q;
      in_ready  = 1'b0;
      rk_idx    = '0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            // Gated by rst_n so the core never advertises readiness in reset.
            in_ready = rst_n;
            if (in_valid) begin
               data_d  = in_data ^ rk_data;
               rnd_d   = RKW'(1);
               state_d = RUN;
            end
         end
         RUN: begin
            busy   = 1'b1;
            rk_idx = rnd_q;
            data_d = round_out;
            if (last_round) begin
               rnd_d   = '0;
               state_d = DONE;
            end else begin
               rnd_d = rnd_q + RKW'(1);
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_data = data_q;

endmodule
